// File: rtl/rc4_pkg.sv
// Shared types for the RC4 phase sequencer: phase encoding, S RAM port bundle
// and the default S RAM width.
package rc4_pkg;

    localparam int RC4_RAM_WIDTH = 8;

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_INIT  = 3'd1,
        PH_KSA   = 3'd2,
        PH_PRGA  = 3'd3,
        PH_DONE  = 3'd4,
        PH_ERROR = 3'd5
    } phase_t;

    typedef struct packed {
        logic [RC4_RAM_WIDTH-1:0] addr;
        logic [RC4_RAM_WIDTH-1:0] wdata;
        logic                     wren;
    } s_port_t;

    // True in the three phases where an engine owns the S RAM.
    function automatic logic is_busy(input phase_t p);
        return (p == PH_INIT) || (p == PH_KSA) || (p == PH_PRGA);
    endfunction

endpackage

// File: rtl/rc4_s_port_mux.sv
// S RAM port select: only the engine owning the current phase reaches the RAM;
// every other phase drives an all-zero port so no stray write can land.
module rc4_s_port_mux
    import rc4_pkg::*;
(
    input  phase_t  phase_i,
    input  s_port_t init_i,
    input  s_port_t ksa_i,
    input  s_port_t prga_i,
    output s_port_t port_o
);

    // Select the owner's port; idle/done/error phases get the zero port.
    always_comb begin
        port_o = '0;
        case (phase_i)
            PH_INIT: port_o = init_i;
            PH_KSA:  port_o = ksa_i;
            PH_PRGA: port_o = prga_i;
            default: port_o = '0;
        endcase
    end

endmodule

// File: rtl/rc4_phase_sequencer.sv
// RC4 decrypt pass controller: steps S-init, KSA and PRGA engines in order and
// grants the single-port S RAM to the active engine.
// Optional per-phase watchdog enabled with the RC4_PHASE_WDT_EN macro.
// RAM_WIDTH must match rc4_pkg::RC4_RAM_WIDTH, which sizes the port bundle.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for a start edge; S RAM port parked at zero
// INIT     | S-init engine running (S[i] = i)
// KSA      | key-schedule engine running
// PRGA     | keystream / decrypt engine running
// DONE     | pass complete; held until the next start edge
// ERROR    | watchdog expired; left only through a start edge
module rc4_phase_sequencer
    import rc4_pkg::*;
#(
    parameter int RAM_WIDTH  = RC4_RAM_WIDTH,
    parameter int WDT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [2:0]           phase,
    output logic                 init_start,
    output logic                 ksa_start,
    output logic                 prga_start,
    input  logic                 init_finished,
    input  logic                 ksa_finished,
    input  logic                 prga_finished,
    input  logic [RAM_WIDTH-1:0] init_addr,
    input  logic [RAM_WIDTH-1:0] ksa_addr,
    input  logic [RAM_WIDTH-1:0] prga_addr,
    input  logic [RAM_WIDTH-1:0] init_wdata,
    input  logic [RAM_WIDTH-1:0] ksa_wdata,
    input  logic [RAM_WIDTH-1:0] prga_wdata,
    input  logic                 init_wren,
    input  logic                 ksa_wren,
    input  logic                 prga_wren,
    output logic [RAM_WIDTH-1:0] s_addr,
    output logic [RAM_WIDTH-1:0] s_wdata,
    output logic                 s_wren
);

    phase_t  state_q, state_d;
    logic    start_q;
    logic    start_edge;
    logic    wdt_expire;
    logic    busy_q, done_q;
    logic    init_start_q, ksa_start_q, prga_start_q;
    s_port_t init_port, ksa_port, prga_port, granted_port;

    assign start_edge = start & ~start_q;

`ifdef RC4_PHASE_WDT_EN
    localparam int CW = $clog2(WDT_CYCLES) + 1;
    localparam logic [CW-1:0] WDT_LAST = CW'(WDT_CYCLES - 1);

    logic [CW-1:0] phase_cycles_q;
    logic          error_q;

    assign wdt_expire = (phase_cycles_q == WDT_LAST);
    assign error      = error_q;

    // Phase cycle counter: restarts on every state change, counts while busy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_cycles_q <= '0;
            error_q        <= 1'b0;
        end else begin
            error_q <= (state_d == PH_ERROR);
            if (state_d != state_q)
                phase_cycles_q <= '0;
            else if (is_busy(state_q))
                phase_cycles_q <= phase_cycles_q + 1'b1;
            else
                phase_cycles_q <= '0;
        end
    end
`else
    assign wdt_expire = 1'b0;
    assign error      = 1'b0;
`endif

    // Next state: abort beats finished, finished beats the watchdog, and only
    // the current phase's finished flag is looked at.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PH_IDLE, PH_DONE, PH_ERROR: begin
                if (start_edge) state_d = PH_INIT;
            end
            PH_INIT: begin
                if (abort)              state_d = PH_IDLE;
                else if (init_finished) state_d = PH_KSA;
                else if (wdt_expire)    state_d = PH_ERROR;
            end
            PH_KSA: begin
                if (abort)              state_d = PH_IDLE;
                else if (ksa_finished)  state_d = PH_PRGA;
                else if (wdt_expire)    state_d = PH_ERROR;
            end
            PH_PRGA: begin
                if (abort)              state_d = PH_IDLE;
                else if (prga_finished) state_d = PH_DONE;
                else if (wdt_expire)    state_d = PH_ERROR;
            end
            default: state_d = PH_IDLE;
        endcase
    end

    // State, start edge history and outputs registered from the next state so
    // each start level drops in the same cycle its phase is left.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= PH_IDLE;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            init_start_q <= 1'b0;
            ksa_start_q  <= 1'b0;
            prga_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_q      <= start;
            busy_q       <= is_busy(state_d);
            done_q       <= (state_d == PH_DONE);
            init_start_q <= (state_d == PH_INIT);
            ksa_start_q  <= (state_d == PH_KSA);
            prga_start_q <= (state_d == PH_PRGA);
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign phase      = state_q;
    assign init_start = init_start_q;
    assign ksa_start  = ksa_start_q;
    assign prga_start = prga_start_q;

    assign init_port = '{addr: init_addr, wdata: init_wdata, wren: init_wren};
    assign ksa_port  = '{addr: ksa_addr,  wdata: ksa_wdata,  wren: ksa_wren};
    assign prga_port = '{addr: prga_addr, wdata: prga_wdata, wren: prga_wren};

    rc4_s_port_mux u_s_port_mux (
        .phase_i (state_q),
        .init_i  (init_port),
        .ksa_i   (ksa_port),
        .prga_i  (prga_port),
        .port_o  (granted_port)
    );

    assign s_addr  = granted_port.addr;
    assign s_wdata = granted_port.wdata;
    assign s_wren  = granted_port.wren;

endmodule

// File: tb/tb_rc4_phase_sequencer.sv
// Directed bench for rc4_phase_sequencer: full pass, mux isolation, abort,
// start edge rules, asynchronous reset and (watchdog build) timeout.
module tb_rc4_phase_sequencer;

`ifdef RC4_PHASE_WDT_EN
    localparam int WDT = 16;
`else
    localparam int WDT = 4096;
`endif

    logic       clk = 1'b0;
    logic       reset_n, start, abort;
    logic       busy, done, error;
    logic [2:0] phase;
    logic       init_start, ksa_start, prga_start;
    logic       init_finished, ksa_finished, prga_finished;
    logic [7:0] init_addr, ksa_addr, prga_addr;
    logic [7:0] init_wdata, ksa_wdata, prga_wdata;
    logic       init_wren, ksa_wren, prga_wren;
    logic [7:0] s_addr, s_wdata;
    logic       s_wren;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rc4_phase_sequencer #(.RAM_WIDTH(8), .WDT_CYCLES(WDT)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .busy(busy), .done(done), .error(error), .phase(phase),
        .init_start(init_start), .ksa_start(ksa_start), .prga_start(prga_start),
        .init_finished(init_finished), .ksa_finished(ksa_finished),
        .prga_finished(prga_finished),
        .init_addr(init_addr), .ksa_addr(ksa_addr), .prga_addr(prga_addr),
        .init_wdata(init_wdata), .ksa_wdata(ksa_wdata), .prga_wdata(prga_wdata),
        .init_wren(init_wren), .ksa_wren(ksa_wren), .prga_wren(prga_wren),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_wren(s_wren)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stay in phase ph for n-1 more cycles, checking phase and one-hot starts.
    task automatic hold_phase(input int n, input logic [2:0] ph, input string tag);
        for (int k = 1; k < n; k++) begin
            tick();
            check({tag, "_phase"}, phase, ph);
            check({tag, "_onehot"}, $countones({init_start, ksa_start, prga_start}), 1);
        end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; abort = 1'b0;
        init_finished = 1'b0; ksa_finished = 1'b0; prga_finished = 1'b0;
        init_addr = 8'h7F; ksa_addr = 8'h3C; prga_addr = 8'hA5;
        init_wdata = 8'h11; ksa_wdata = 8'h22; prga_wdata = 8'h33;
        init_wren = 1'b0; ksa_wren = 1'b0; prga_wren = 1'b0;
        #12;
        check("rst_phase", phase, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_starts", {init_start, ksa_start, prga_start}, 0);
        check("rst_s_addr", s_addr, 0);
        tick();
        reset_n = 1'b1;
        tick();

        // Abort in IDLE does nothing.
        abort = 1'b1;
        tick();
        check("idle_abort_phase", phase, 0);
        abort = 1'b0;

        // Full pass: start edge -> INIT one clock later.
        start = 1'b1;
        tick();
        check("pass_busy", busy, 1);
        check("pass_init", phase, 1);
        check("pass_init_start", init_start, 1);

        // Mux isolation in INIT.
        ksa_wren = 1'b1;
        #1;
        check("init_nonowner_wren", s_wren, 0);
        check("init_s_addr", s_addr, 8'h7F);
        init_wren = 1'b1;
        #1;
        check("init_owner_wren", s_wren, 1);
        check("init_s_wdata", s_wdata, 8'h11);

        // Stale finished flags from other phases.
        ksa_finished = 1'b1; prga_finished = 1'b1;
        tick();
        check("stale_fin_phase", phase, 1);
        ksa_finished = 1'b0; prga_finished = 1'b0;
        hold_phase(255, 3'd1, "init");
        init_finished = 1'b1;
        tick();
        init_finished = 1'b0;
        check("pass_ksa", phase, 2);
        check("pass_ksa_starts", {init_start, ksa_start, prga_start}, 3'b010);

        // Mux isolation in KSA.
        ksa_wren = 1'b0;
        #1;
        check("ksa_nonowner_wren", s_wren, 0);
        check("ksa_s_addr", s_addr, 8'h3C);
        ksa_wren = 1'b1;
        #1;
        check("ksa_owner_wren", s_wren, 1);
        check("ksa_s_wdata", s_wdata, 8'h22);
        init_wren = 1'b0; ksa_wren = 1'b0;

        // Start edge while busy is ignored.
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        check("busy_edge_phase", phase, 2);
        hold_phase(766, 3'd2, "ksa");
        ksa_finished = 1'b1;
        tick();
        ksa_finished = 1'b0;
        check("pass_prga", phase, 3);
        check("prga_s_addr", s_addr, 8'hA5);
        hold_phase(40, 3'd3, "prga");
        prga_finished = 1'b1;
        tick();
        prga_finished = 1'b0;
        check("pass_done_phase", phase, 4);
        check("pass_done", done, 1);
        check("pass_done_busy", busy, 0);
        check("pass_done_starts", {init_start, ksa_start, prga_start}, 0);
        prga_wren = 1'b1;
        #1;
        check("done_s_wren", s_wren, 0);
        check("done_s_addr", s_addr, 0);
        prga_wren = 1'b0;

        // Held-high start does not retrigger.
        repeat (5) tick();
        check("done_held_phase", phase, 4);
        check("done_held", done, 1);

        // Fresh edge from DONE restarts.
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        check("restart_phase", phase, 1);
        check("restart_done", done, 0);

        // Abort in KSA beats a simultaneous ksa_finished.
        init_finished = 1'b1;
        tick();
        init_finished = 1'b0;
        check("abort_pre_phase", phase, 2);
        ksa_wren = 1'b1;
        abort = 1'b1; ksa_finished = 1'b1;
        tick();
        abort = 1'b0; ksa_finished = 1'b0;
        check("abort_phase", phase, 0);
        check("abort_ksa_start", ksa_start, 0);
        check("abort_s_wren", s_wren, 0);
        check("abort_busy", busy, 0);
        ksa_wren = 1'b0;

        // Asynchronous reset in the middle of PRGA.
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        init_finished = 1'b1;
        tick();
        init_finished = 1'b0;
        ksa_finished = 1'b1;
        tick();
        ksa_finished = 1'b0;
        check("pre_rst_prga", phase, 3);
        prga_wren = 1'b1;
        tick();
        reset_n = 1'b0;
        #1;
        check("midrst_phase", phase, 0);
        check("midrst_busy", busy, 0);
        check("midrst_prga_start", prga_start, 0);
        check("midrst_s_wren", s_wren, 0);
        prga_wren = 1'b0;
        tick();
        reset_n = 1'b1;
        start = 1'b0;
        tick();
        check("post_rst_phase", phase, 0);

`ifdef RC4_PHASE_WDT_EN
        // Watchdog: KSA never finishes -> ERROR 16 cycles after entering KSA.
        start = 1'b1;
        tick();
        init_finished = 1'b1;
        tick();
        init_finished = 1'b0;
        check("wdt_ksa", phase, 2);
        for (int k = 1; k < 16; k++) begin
            tick();
            check("wdt_wait_phase", phase, 2);
        end
        tick();
        check("wdt_error_phase", phase, 5);
        check("wdt_error", error, 1);
        check("wdt_starts", {init_start, ksa_start, prga_start}, 0);
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        check("wdt_restart_phase", phase, 1);
        check("wdt_restart_error", error, 0);
`else
        check("no_wdt_error", error, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
